resp_sig_compactor: RTL and testbench
=====================================

Name: resp_sig_compactor

Overview:
- Response-side counterpart to the LCG stimulus generator. It accepts the DUT's wide flat output vector once per handshake and splits it into 32-bit chunks.
- Each chunk is folded into a running 32-bit LCG-style signature.
- After a programmed number of vectors it compares the signature against an expected value and reports done/pass.
- It sits between the DUT's out_flat and the sim/regression status logic, so a run can be checked with one 32-bit compare instead of a full cycle-by-cycle dump.

Parameters:
- OUT_W, 330, width of the response vector.
- SEED, 32'h0000_0000, signature value loaded on start.
- MULT, 32'h41C6_4E6D, fold multiplier (same constant as the stimulus LCG).
- INC, 32'h0000_3039, fold increment.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a run from IDLE or DONE, ignored otherwise.
- num_vectors  input  32  vectors per run; sampled on accepted start.
- expected_sig  input  32  golden signature; sampled on accepted start.
- vec_valid  input  1  response vector valid.
- vec_ready  output  1  block can accept a vector.
- vec_data  input  OUT_W  response vector; sampled only on handshake.
- busy  output  1  high in COLLECT or FOLD.
- done  output  1  sticky; high in DONE.
- pass  output  1  valid when done; expected_sig matched.
- sig  output  32  current signature register.
- vec_count  output  32  vectors fully folded this run.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; sig=SEED; vec_count=0.
  - vec_ready=0, busy=0, done=0, pass=0.
  - The chunk buffer is cleared to 0.
  - Reset mid-run aborts the run with no residue.
- NCHUNK = ceil(OUT_W/32), which is 11 for the default. Chunk k = vec_data[32k+31:32k]. The last chunk is zero-extended above bit OUT_W-1.
- Fold step: sig_next = ((sig ^ chunk) * MULT + INC) mod 2^32. Keep only the low 32 bits of the product.
- States: IDLE, COLLECT, FOLD, DONE.
- IDLE:
  - start=1 latches num_vectors and expected_sig, sets sig=SEED and vec_count=0.
  - If num_vectors==0, go to DONE, with pass=(SEED==expected_sig) registered on entry.
  - Otherwise go to COLLECT.
- COLLECT:
  - vec_ready=1.
  - On vec_valid&vec_ready, register vec_data into the buffer, set chunk_idx=0 and go to FOLD.
  - Without valid, stay; there is no timeout.
- FOLD:
  - vec_ready=0.
  - Each cycle folds chunk[chunk_idx] into sig and increments chunk_idx.
  - On the cycle folding chunk NCHUNK-1, vec_count increments.
  - If vec_count+1==num_vectors_latched, go to DONE with pass=(sig_next==expected_sig).
  - Otherwise go back to COLLECT.
- Throughput: 1 vector per NCHUNK+1 cycles.
  - Handshake edge to first fold: 1 cycle.
  - Last fold to DONE: done/pass visible in the cycle after the final fold edge.
- DONE:
  - done=1; pass, sig and vec_count hold.
  - vec_ready=0; vec_valid is ignored.
  - start re-arms exactly as from IDLE, and done drops in the same edge.
- start in COLLECT or FOLD: ignored, with no effect on state or latches.
- vec_valid in IDLE, FOLD or DONE: no handshake, data is dropped, and no error is flagged.
- vec_count wraps mod 2^32. This is unreachable when num_vectors ≤ 2^32-1, since the run terminates first.

Decomposition:
- Package resp_sig_pkg holds:
  - the state enum typedef (IDLE, COLLECT, FOLD, DONE);
  - default MULT/INC/SEED localparams;
  - function nchunk(int w), returning ceil(w/32);
  - typedef sig_t (logic [31:0]).
- One combinational sub-module, sig_fold_step, implements the fold: inputs sig, chunk; output sig_next. It is shared by the FSM and reusable by the bench's reference model.
- The top holds the FSM, chunk buffer/index, counters and compare.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-FOLD, then release.
  - Required response: state IDLE, sig=0, vec_count=0, vec_ready=0, done=0, pass=0 immediately, with no clock needed.
- Single chunk:
  - Stimulus: OUT_W=32, SEED=0, num_vectors=1, vec_data=0, expected_sig=32'h0000_3039.
  - Required response: done 2 cycles after handshake, sig=32'h3039, pass=1.
  - Repeat with vec_data=1 and expected_sig=32'h41C6_7EA6: pass=1.
- Mismatch:
  - Stimulus: same as the single-chunk case but expected_sig=32'h3038.
  - Required response: done=1, pass=0, sig=32'h3039.
- Default width:
  - Stimulus: OUT_W=330, num_vectors=300, LCG-driven vec_data with random valid gaps.
  - Required response: vec_ready low exactly 11 cycles after each handshake; vec_count=300; sig equals the bench model built on sig_fold_step; pass follows the compare.
- Zero vectors:
  - Stimulus: num_vectors=0, expected_sig=SEED.
  - Required response: DONE one cycle after start, pass=1, vec_ready never high.
- Protocol corners:
  - Stimulus: start pulses during FOLD; vec_valid held high through FOLD and DONE.
  - Required response: no restart, no extra vec_count increments.
  - Stimulus: start in DONE.
  - Required response: done=0 next cycle, sig=SEED.

Source files
------------

// File: rtl/resp_sig_pkg.sv
// Shared types and constants for the response signature compactor.
// The fold constants match the stimulus-side LCG so both ends use the same recurrence.
package resp_sig_pkg;

  typedef logic [31:0] sig_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FOLD,
    DONE
  } state_t;

  localparam sig_t DEF_SEED = 32'h0000_0000;
  localparam sig_t DEF_MULT = 32'h41C6_4E6D;
  localparam sig_t DEF_INC  = 32'h0000_3039;

  // Number of 32-bit chunks needed to cover a w-bit vector.
  function automatic int nchunk(int w);
    return (w + 31) / 32;
  endfunction

endpackage

// File: rtl/sig_fold_step.sv
// One LCG-style fold: sig_next = (sig ^ chunk) * MULT + INC, modulo 2^32.
// Purely combinational so it can be reused outside the compactor FSM.
module sig_fold_step
  import resp_sig_pkg::*;
#(
  parameter sig_t MULT = DEF_MULT,
  parameter sig_t INC  = DEF_INC
) (
  input  sig_t sig,
  input  sig_t chunk,
  output sig_t sig_next
);

  sig_t mixed;

  assign mixed    = sig ^ chunk;
  // 32-bit context keeps only the low word of the product.
  assign sig_next = mixed * MULT + INC;

endmodule

// File: rtl/resp_sig_compactor.sv
// Folds each accepted response vector, 32 bits per cycle, into a running signature
// and compares it with the golden value once the programmed vector count is reached.
module resp_sig_compactor
  import resp_sig_pkg::*;
#(
  parameter int   OUT_W = 330,
  parameter sig_t SEED  = DEF_SEED,
  parameter sig_t MULT  = DEF_MULT,
  parameter sig_t INC   = DEF_INC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      num_vectors,
  input  logic [31:0]      expected_sig,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [OUT_W-1:0] vec_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      sig,
  output logic [31:0]      vec_count
);

  localparam int NCHUNK = nchunk(OUT_W);
  localparam int PAD_W  = NCHUNK * 32;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t                   state_q, state_d;
  logic [NCHUNK-1:0][31:0]  chunk_buf;
  logic [CW-1:0]            chunk_idx;
  logic [PAD_W-1:0]         vec_pad;
  sig_t                     sig_q, sig_next, chunk_cur;
  logic [31:0]              nvec_q;
  sig_t                     exp_q;
  logic                     pass_q;
  logic                     last_chunk, last_vec;

  // Zero-extend so the top chunk carries zeros above OUT_W-1.
  assign vec_pad    = PAD_W'(vec_data);
  assign chunk_cur  = chunk_buf[chunk_idx];
  assign last_chunk = (chunk_idx == CW'(NCHUNK - 1));
  assign last_vec   = ((vec_count + 32'd1) == nvec_q);

  sig_fold_step #(
    .MULT (MULT),
    .INC  (INC)
  ) u_fold (
    .sig      (sig_q),
    .chunk    (chunk_cur),
    .sig_next (sig_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (num_vectors == 32'd0) ? DONE : COLLECT;
      COLLECT:    if (vec_valid) state_d = FOLD;
      FOLD:       if (last_chunk) state_d = last_vec ? DONE : COLLECT;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sig_q     <= SEED;
      vec_count <= '0;
      nvec_q    <= '0;
      exp_q     <= '0;
      pass_q    <= 1'b0;
      chunk_buf <= '0;
      chunk_idx <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            nvec_q    <= num_vectors;
            exp_q     <= expected_sig;
            sig_q     <= SEED;
            vec_count <= '0;
            pass_q    <= (num_vectors == 32'd0) && (SEED == expected_sig);
          end
        end
        COLLECT: begin
          if (vec_valid) begin
            chunk_buf <= vec_pad;
            chunk_idx <= '0;
          end
        end
        FOLD: begin
          sig_q     <= sig_next;
          chunk_idx <= chunk_idx + CW'(1);
          if (last_chunk) begin
            vec_count <= vec_count + 32'd1;
            if (last_vec) pass_q <= (sig_next == exp_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign vec_ready = (state_q == COLLECT);
  assign busy      = (state_q == COLLECT) || (state_q == FOLD);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign sig       = sig_q;

endmodule

// File: tb/tb_resp_sig_compactor.sv
// Directed bench for resp_sig_compactor: a 32-bit instance for hand-computed folds and
// the default 330-bit instance for long runs; a monitor scores every rising done.
module tb_resp_sig_compactor;

  localparam logic [31:0] M = 32'h41C6_4E6D;
  localparam logic [31:0] I = 32'h0000_3039;

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_start, a_valid, a_ready, a_busy, a_done, a_pass;
  logic [31:0] a_num, a_exp, a_data, a_sig, a_cnt;
  logic        b_start, b_valid, b_ready, b_busy, b_done, b_pass;
  logic [31:0] b_num, b_exp, b_sig, b_cnt;
  logic [329:0] b_data;

  resp_sig_compactor #(.OUT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .num_vectors(a_num), .expected_sig(a_exp),
    .vec_valid(a_valid), .vec_ready(a_ready), .vec_data(a_data), .busy(a_busy),
    .done(a_done), .pass(a_pass), .sig(a_sig), .vec_count(a_cnt)
  );

  resp_sig_compactor dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .num_vectors(b_num), .expected_sig(b_exp),
    .vec_valid(b_valid), .vec_ready(b_ready), .vec_data(b_data), .busy(b_busy),
    .done(b_done), .pass(b_pass), .sig(b_sig), .vec_count(b_cnt)
  );

  int checks = 0;
  int passed = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] lcg = 32'h1234_5678;
  logic [329:0] vecs[300];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] c);
    return (s ^ c) * M + I;
  endfunction

  function automatic logic [31:0] vsig(input logic [31:0] s, input logic [329:0] v);
    logic [351:0] p;
    p = {22'b0, v};
    for (int k = 0; k < 11; k++) s = fold(s, p[32*k +: 32]);
    return s;
  endfunction

  task automatic gen_vec(output logic [329:0] v);
    logic [351:0] w;
    for (int k = 0; k < 11; k++) begin
      lcg = lcg * M + I;
      w[32*k +: 32] = lcg;
    end
    v = w[329:0];
  endtask

  // Scoreboard monitor: each rising done consumes one expected result.
  logic a_dq = 1'b0, b_dq = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (a_done && !a_dq) begin
      chk("a_q_nonempty", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_sig", a_sig, e.sig);
        chk("a_pass", 32'(a_pass), 32'(e.pass));
        chk("a_vec_count", a_cnt, e.cnt);
      end
    end
    if (b_done && !b_dq) begin
      chk("b_q_nonempty", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_sig", b_sig, e.sig);
        chk("b_pass", 32'(b_pass), 32'(e.pass));
        chk("b_vec_count", b_cnt, e.cnt);
      end
    end
    a_dq = a_done;
    b_dq = b_done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_go(input logic [31:0] num, input logic [31:0] ex);
    a_start = 1'b1; a_num = num; a_exp = ex;
    step();
    a_start = 1'b0;
  endtask

  task automatic b_go(input logic [31:0] num, input logic [31:0] ex);
    b_start = 1'b1; b_num = num; b_exp = ex;
    step();
    b_start = 1'b0;
  endtask

  // Single-vector run on the 32-bit instance, started from DONE.
  task automatic a_run1(input logic [31:0] d, input logic [31:0] ex, input logic ps,
                        input logic [31:0] sg);
    qa.push_back('{sig: sg, pass: ps, cnt: 32'd1});
    a_go(32'd1, ex);
    chk("a_done_drops_on_start", 32'(a_done), 32'd0);
    chk("a_sig_reseeded", a_sig, 32'd0);
    chk("a_ready_collect", 32'(a_ready), 32'd1);
    a_data = d; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    chk("a_not_done_in_fold", 32'(a_done), 32'd0);
    step();
    chk("a_done_latency", 32'(a_done), 32'd1);
    step();
  endtask

  // Sends one vector and measures how long vec_ready stays low afterwards.
  task automatic b_send(input logic [329:0] d, input bit hold);
    int n;
    b_data = d; b_valid = 1'b1;
    n = 0;
    while (!b_ready && n < 200) begin step(); n++; end
    if (!b_ready) chk("b_ready_timeout", 32'(b_ready), 32'd1);
    step();
    if (!hold) b_valid = 1'b0;
    n = 0;
    while (!b_ready && !b_done && n < 50) begin n++; step(); end
    chk("b_ready_low_cycles", 32'(n), 32'd11);
  endtask

  initial begin
    logic [31:0] e2, e300;
    int n;
    rst_n = 1'b0;
    a_start = 0; a_num = 0; a_exp = 0; a_valid = 0; a_data = 0;
    b_start = 0; b_num = 0; b_exp = 0; b_valid = 0; b_data = '0;
    #1;
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_a_sig", a_sig, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Abort a 330-bit run mid-fold with an async reset.
    b_go(32'd5, 32'd0);
    gen_vec(vecs[0]);
    b_data = vecs[0]; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step(); step(); step();
    chk("pre_rst_b_busy", 32'(b_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_b_sig", b_sig, 32'd0);
    chk("rst_b_cnt", b_cnt, 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_b_done", 32'(b_done), 32'd0);
    chk("rst_b_pass", 32'(b_pass), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_b_idle", 32'(b_busy), 32'd0);

    // Zero vectors: DONE right after start, never ready.
    qa.push_back('{sig: 32'd0, pass: 1'b1, cnt: 32'd0});
    a_go(32'd0, 32'd0);
    chk("zero_done", 32'(a_done), 32'd1);
    chk("zero_pass", 32'(a_pass), 32'd1);
    chk("zero_ready", 32'(a_ready), 32'd0);
    step();

    a_run1(32'd0, 32'h0000_3039, 1'b1, 32'h0000_3039);
    a_run1(32'd1, 32'h41C6_7EA6, 1'b1, 32'h41C6_7EA6);
    a_run1(32'd0, 32'h0000_3038, 1'b0, 32'h0000_3039);

    // Protocol corners: start during FOLD ignored, valid held through FOLD and DONE.
    gen_vec(vecs[0]); gen_vec(vecs[1]);
    e2 = vsig(vsig(32'd0, vecs[0]), vecs[1]);
    qb.push_back('{sig: e2, pass: 1'b1, cnt: 32'd2});
    b_go(32'd2, e2);
    b_data = vecs[0]; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    b_start = 1'b1; b_num = 32'd7; b_exp = 32'd0;
    step();
    b_start = 1'b0;
    chk("start_in_fold_busy", 32'(b_busy), 32'd1);
    b_send(vecs[1], 1'b1);
    for (int k = 0; k < 5; k++) step();
    chk("hold_valid_cnt", b_cnt, 32'd2);
    chk("hold_valid_ready", 32'(b_ready), 32'd0);
    chk("hold_valid_done", 32'(b_done), 32'd1);
    chk("hold_valid_sig", b_sig, e2);
    b_valid = 1'b0;
    step();

    // 300-vector run with random valid gaps.
    e300 = 32'd0;
    for (int v = 0; v < 300; v++) begin
      gen_vec(vecs[v]);
      e300 = vsig(e300, vecs[v]);
    end
    qb.push_back('{sig: e300, pass: 1'b1, cnt: 32'd300});
    b_go(32'd300, e300);
    for (int v = 0; v < 300; v++) begin
      n = int'($urandom_range(0, 3));
      for (int g = 0; g < n; g++) step();
      b_send(vecs[v], 1'b0);
    end
    chk("long_done", 32'(b_done), 32'd1);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin step(); n++; end
    step();
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
